// File: rtl/multirate_mac_accum_pkg.sv
// Shared constants, FSM state type and helpers for the multirate MAC accumulator.
package multirate_pkg;

  localparam int PROD_W_DEF = 29;
  localparam int OUT_W_DEF  = 16;
  localparam int ACC_W_DEF  = 36;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multirate_mac_accum_if.sv
// Product input stream, sample output stream, status flags and FSM debug state.
// Handshake: a beat transfers on the rising edge where tvalid && tready are both 1.
interface multirate_mac_accum_if
  import multirate_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
);
  logic signed [PROD_W-1:0] prod_tdata;
  logic                     prod_tvalid;
  logic                     prod_tready;
  logic                     prod_tlast;
  logic signed [OUT_W-1:0]  out_tdata;
  logic                     out_tvalid;
  logic                     out_tready;
  logic                     frame_err;
  logic                     sat_flag;
  state_t                   state_dbg;

  modport master (
    output prod_tdata, prod_tvalid, prod_tlast, out_tready,
    input  prod_tready, out_tdata, out_tvalid, frame_err, sat_flag, state_dbg
  );

  modport slave (
    input  prod_tdata, prod_tvalid, prod_tlast, out_tready,
    output prod_tready, out_tdata, out_tvalid, frame_err, sat_flag, state_dbg
  );
endinterface

// File: rtl/multirate_mac_accum_round_sat.sv
// Combinational rescale of the accumulated sum: optional round half-up, arithmetic
// shift, clip to OUT_W. Rounding is compiled in when MULTIRATE_ROUND_EN is defined.
module multirate_round_sat #(
  parameter int ACC_W      = 36,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 12
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r;
  logic signed [ACC_W-1:0] s;

`ifdef MULTIRATE_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_SHIFT - 1);
  assign r = din + HALF;
`else
  assign r = din;
`endif

  assign s = r >>> FRAC_SHIFT;

  always_comb begin
    dout = s[OUT_W-1:0];
    sat  = 1'b0;
    if (s > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (s < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
  end
endmodule

// File: rtl/multirate_mac_accum.sv
// Polyphase decimating accumulator: sums NUM_TAPS products per sample, rescales,
// saturates and holds the sample on a valid/ready stream. Option: MULTIRATE_ROUND_EN.
module multirate_mac_accum
  import multirate_pkg::*;
#(
  parameter int PROD_W     = PROD_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int NUM_TAPS   = 16,
  parameter int FRAC_SHIFT = 12
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  multirate_mac_accum_if.slave bus
);
  localparam int CNT_W = clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  state_t                  state;
  logic [CNT_W-1:0]        tap_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] rs_data;
  logic                    rs_sat;
  logic                    final_tap;
  logic                    accept;
  logic                    final_acc;

  assign final_tap = (tap_cnt == LAST_TAP);
  // Only a final tap can stall: its result needs the output register freed this cycle.
  assign bus.prod_tready = (state == ACCUM) || !final_tap || bus.out_tready;
  assign accept    = bus.prod_tvalid && bus.prod_tready;
  assign final_acc = accept && final_tap;
  assign prod_ext  = {{(ACC_W-PROD_W){bus.prod_tdata[PROD_W-1]}}, bus.prod_tdata};
  assign sum       = acc + prod_ext;

  assign bus.out_tvalid = (state == HOLD);
  assign bus.state_dbg  = state;

  multirate_round_sat #(
    .ACC_W     (ACC_W),
    .OUT_W     (OUT_W),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_round_sat (
    .din (sum),
    .dout(rs_data),
    .sat (rs_sat)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc           <= '0;
      tap_cnt       <= '0;
      state         <= ACCUM;
      bus.out_tdata <= '0;
      bus.sat_flag  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      if (accept) begin
        if (final_tap) begin
          acc     <= '0;
          tap_cnt <= '0;
        end else begin
          acc     <= sum;
          tap_cnt <= tap_cnt + CNT_W'(1);
        end
        if (bus.prod_tlast != final_tap) bus.frame_err <= 1'b1;
      end
      if (final_acc) begin
        state         <= HOLD;
        bus.out_tdata <= rs_data;
        bus.sat_flag  <= rs_sat;
      end else if ((state == HOLD) && bus.out_tready) begin
        state <= ACCUM;
      end
    end
  end
endmodule
